// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter: per-requester FIFOs, round-robin
// grant of queue heads into a registered write stage, plus a pending-register map.
module reg_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [3:0]        req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [3:0]        req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              reg_write,
  output logic [3:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]        in_valid;
  logic [3:0]        in_reg  [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        not_empty;

  logic [3:0]        q_reg_q  [2][DEPTH];
  logic [DATA_W-1:0] q_data_q [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [CNT_W-1:0]  cnt_q    [2];

  logic              alive_q;
  logic              last_q;
  logic              grant_any;
  logic              grant_sel;
  logic [3:0]        head_reg;
  logic [DATA_W-1:0] head_data;

  logic              reg_write_q;
  logic [3:0]        write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic [15:0]       pend_vec;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_reg[0]  = req0_reg;
  assign in_reg[1]  = req1_reg;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  // alive_q holds the readies low until the first edge after reset release
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      ready[i]     = alive_q && (cnt_q[i] < CNT_W'(DEPTH));
      push[i]      = in_valid[i] && ready[i];
    end
  end

  // last_q names the requester granted most recently; both waiting -> the other one
  always_comb begin
    grant_any = |not_empty;
    grant_sel = not_empty[1] && (!not_empty[0] || !last_q);
    pop       = '0;
    if (grant_any) pop[grant_sel] = 1'b1;
    head_reg  = q_reg_q[grant_sel][rd_ptr_q[grant_sel]];
    head_data = q_data_q[grant_sel][rd_ptr_q[grant_sel]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        q_reg_q[i][wr_ptr_q[i]]  <= in_reg[i];
        q_data_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // A granted write to r_0 still pops, but never raises the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q      <= 1'b0;
      last_q       <= 1'b1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      alive_q     <= 1'b1;
      reg_write_q <= grant_any && (head_reg != 4'd0);
      if (grant_any) begin
        last_q       <= grant_sel;
        write_reg_q  <= head_reg;
        write_data_q <= head_data;
      end
    end
  end

  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CNT_W'(k) < cnt_q[i]) pend_vec[q_reg_q[i][rd_ptr_q[i] + PTR_W'(k)]] = 1'b1;
      end
    end
    if (reg_write_q) pend_vec[write_reg_q] = 1'b1;
    pend_vec[0] = 1'b0;
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign pending    = pend_vec;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a queue-level reference model.
module tb_reg_write_arbiter;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [3:0]        req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [3:0]        req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              reg_write;
  logic [3:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [15:0]       pending;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one FIFO of {reg,data} per requester plus the write stage
  logic [19:0] mq0[$];
  logic [19:0] mq1[$];
  int          m_last;
  bit          m_alive;
  bit          m_rw;
  bit          m_x0;
  bit          m_x1;
  logic [3:0]  m_wreg;
  logic [15:0] m_wdata;

  reg_write_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    m_last  = 1;
    m_alive = 0;
    m_rw    = 0;
    m_wreg  = '0;
    m_wdata = '0;
    m_x0    = 0;
    m_x1    = 0;
  endfunction

  function automatic void model_edge();
    logic [19:0] e;
    int g;
    m_x0 = req0_valid && m_alive && (mq0.size() < DEPTH);
    m_x1 = req1_valid && m_alive && (mq1.size() < DEPTH);
    g = -1;
    if (mq0.size() > 0 && mq1.size() > 0) g = (m_last == 0) ? 1 : 0;
    else if (mq0.size() > 0) g = 0;
    else if (mq1.size() > 0) g = 1;
    m_rw = 0;
    e = '0;
    if (g == 0) e = mq0.pop_front();
    if (g == 1) e = mq1.pop_front();
    if (g >= 0) begin
      m_last = g;
      if (e[19:16] != 4'd0) begin
        m_rw    = 1;
        m_wreg  = e[19:16];
        m_wdata = e[15:0];
      end
    end
    if (m_x0) mq0.push_back({req0_reg, req0_data});
    if (m_x1) mq1.push_back({req1_reg, req1_data});
    m_alive = 1;
  endfunction

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = '0;
    foreach (mq0[i]) p[mq0[i][19:16]] = 1'b1;
    foreach (mq1[i]) p[mq1[i][19:16]] = 1'b1;
    if (m_rw) p[m_wreg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_outputs();
    chk("ready0", 32'(req0_ready), 32'(m_alive && mq0.size() < DEPTH));
    chk("ready1", 32'(req1_ready), 32'(m_alive && mq1.size() < DEPTH));
    chk("reg_write", 32'(reg_write), 32'(m_rw));
    chk("pending", 32'(pending), 32'(model_pending()));
    if (m_rw) begin
      chk("write_reg", 32'(write_reg), 32'(m_wreg));
      chk("write_data", 32'(write_data), 32'(m_wdata));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_zero_chk();
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    chk("rst_write_data", 32'(write_data), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
  endtask

  // Called just after a step: low from +2 ns to +7 ns, between two rising edges
  task automatic pulse_reset();
    #1;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    reset_zero_chk();
    model_reset();
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] seq;
    int p0, p1;

    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_reg   = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_reg   = '0;
    req1_data  = '0;
    model_reset();
    #3;
    reset_zero_chk();
    #9;
    rst_n = 1'b1;

    // Single write with latency and pending tracking
    step();
    chk("ready0_after_release", 32'(req0_ready), 1);
    chk("ready1_after_release", 32'(req1_ready), 1);
    req0_valid = 1'b1; req0_reg = 4'd3; req0_data = 16'h1234;
    step();
    req0_valid = 1'b0;
    chk("single_pend_queued", 32'(pending[3]), 1);
    chk("single_no_early_write", 32'(reg_write), 0);
    step();
    chk("single_rw", 32'(reg_write), 1);
    chk("single_reg", 32'(write_reg), 3);
    chk("single_data", 32'(write_data), 32'h1234);
    chk("single_pend_staged", 32'(pending[3]), 1);
    step();
    chk("single_rw_done", 32'(reg_write), 0);
    chk("single_pend_clear", 32'(pending[3]), 0);

    // Contention: data bit 15 tags the requester, grants must alternate from 0
    pulse_reset();
    step();
    seq = 16'd1;
    req0_valid = 1'b1; req0_reg = 4'd1; req0_data = 16'h0000;
    req1_valid = 1'b1; req1_reg = 4'd2; req1_data = 16'h8000;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i > 0) begin
        chk("cont_rw", 32'(reg_write), 1);
        chk("cont_src", 32'(write_data[15]), 32'((i - 1) % 2));
      end
      if (m_x0) begin req0_data = {1'b0, seq[14:0]}; seq++; end
      if (m_x1) begin req1_data = {1'b1, seq[14:0]}; seq++; end
    end
    idle(4);

    // Backpressure on requester 1 with a third write held while full
    pulse_reset();
    step();
    req0_valid = 1'b1; req0_reg = 4'd4; req0_data = 16'hA001;
    req1_valid = 1'b1; req1_reg = 4'd6; req1_data = 16'hB001;
    step();
    req0_data = 16'hA002;
    req1_data = 16'hB002;
    step();
    chk("bp_ready1_full", 32'(req1_ready), 0);
    req0_valid = 1'b0;
    req1_data  = 16'hB003;
    step();
    chk("bp_w1", 32'(write_data), 32'hB001);
    step();
    req1_valid = 1'b0;
    chk("bp_w2", 32'(write_data), 32'hA002);
    step();
    chk("bp_w3", 32'(write_data), 32'hB002);
    step();
    chk("bp_w4", 32'(write_data), 32'hB003);
    chk("bp_w4_rw", 32'(reg_write), 1);
    idle(3);

    // r_0 filter
    req0_valid = 1'b1; req0_reg = 4'd0; req0_data = 16'hDEAD;
    step();
    req0_reg = 4'd5; req0_data = 16'h0555;
    step();
    req0_valid = 1'b0;
    chk("r0_no_strobe", 32'(reg_write), 0);
    chk("r0_pend0", 32'(pending[0]), 0);
    chk("r0_pend5", 32'(pending[5]), 1);
    step();
    chk("r0_next_rw", 32'(reg_write), 1);
    chk("r0_next_reg", 32'(write_reg), 5);
    chk("r0_next_data", 32'(write_data), 32'h0555);
    idle(2);

    // Same register from both requesters right after reset
    pulse_reset();
    step();
    req0_valid = 1'b1; req0_reg = 4'd7; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_reg = 4'd7; req1_data = 16'hBBBB;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("same_first", 32'(write_data), 32'hAAAA);
    chk("same_first_reg", 32'(write_reg), 7);
    step();
    chk("same_second", 32'(write_data), 32'hBBBB);
    chk("same_pend_held", 32'(pending[7]), 1);
    step();
    chk("same_done_rw", 32'(reg_write), 0);
    chk("same_pend_clear", 32'(pending[7]), 0);

    // Mid-flight reset with three writes queued or staged
    req0_valid = 1'b1; req0_reg = 4'd9; req0_data = 16'h0900;
    req1_valid = 1'b1; req1_reg = 4'd10; req1_data = 16'h0A00;
    step();
    req0_data = 16'h0901;
    req1_valid = 1'b0;
    step();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_write", 32'(reg_write), 0);
    end

    // Random traffic, with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 0) begin
        p0 = $urandom_range(20, 100);
        p1 = $urandom_range(20, 100);
      end
      if (m_x0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 99) < p0);
        req0_reg   = 4'($urandom_range(0, 15));
        req0_data  = 16'($urandom);
      end
      if (m_x1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 99) < p1);
        req1_reg   = 4'($urandom_range(0, 15));
        req1_data  = 16'($urandom);
      end
      step();
      if (c == 200) pulse_reset();
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, 16, write-data width; SHALL match the register-file data width.
REQ-002 Parameter DEPTH, 2, entries per requester queue; SHALL be a power of two, 2 or greater.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0_valid  in  1  requester 0 offers a write.
REQ-007 req0_reg  in  4  requester 0 destination register.
REQ-008 req0_data  in  DATA_W  requester 0 write data.
REQ-009 req0_ready  out  1  requester 0 queue can accept.
REQ-010 req1_valid, req1_reg, req1_data, req1_ready SHALL mirror REQ-006..009 for requester 1.
REQ-011 reg_write  out  1  write strobe to the register file.
REQ-012 write_reg  out  4  register-file write address.
REQ-013 write_data  out  DATA_W  register-file write data.
REQ-014 pending  out  16  bit i set while any queued or staged write targets register i.

Function
REQ-015 A transfer SHALL occur on a rising edge where reqN_valid and reqN_ready are both 1; {reg,data} SHALL be pushed into queue N.
REQ-016 reqN_ready SHALL be 1 exactly when queue N count < DEPTH, from registered count only, with no same-cycle pop bypass.
REQ-017 Requesters SHALL hold valid, reg and data stable until the transfer; the block need not detect a violation.
REQ-018 Each cycle at most one queue head SHALL be granted: one non-empty queue wins alone; if both are non-empty, the queue not granted most recently wins.
REQ-019 The last-grant pointer SHALL update only on a grant; after reset it SHALL favour requester 0.
REQ-020 The granted head SHALL pop and load the output stage on the same edge; reg_write, write_reg and write_data SHALL be registered outputs.
REQ-021 Latency: a write pushed into an empty queue at edge k with no contention SHALL drive reg_write=1 during the cycle after edge k+1.
REQ-022 Throughput SHALL be one write per cycle sustained; reg_write SHALL be 0 in any cycle after an edge with no grant.
REQ-023 A granted write with reg=0 SHALL be popped and counted as a grant, but SHALL leave reg_write=0 (r_0 is never written).
REQ-024 A simultaneous push and pop on the same queue SHALL keep the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 Writes to the same register from both requesters SHALL reach the register file in grant order; the later grant wins.
REQ-026 Per requester, order SHALL be strictly FIFO.
REQ-027 pending SHALL be combinational from queue contents and the output stage, and pending[0] SHALL always be 0.
REQ-028 A pending bit SHALL clear in the cycle after the last matching write leaves the output stage.

Reset
REQ-029 When rst_n is low, all outputs SHALL immediately be 0: reg_write, write_reg, write_data, pending, req0_ready and req1_ready.
REQ-030 Both queues SHALL empty and the last-grant pointer SHALL favour requester 0.
REQ-031 Reset during operation SHALL discard all queued and staged writes; no reg_write pulse SHALL follow the deassertion.
REQ-032 After rst_n rises, both readies SHALL be 1 from the first rising edge.

Verification
REQ-033 Single write: req0 {reg=3, data=16'h1234} at edge k -> reg_write=1, write_reg=3, write_data=16'h1234 in the cycle after edge k+1; pending[3]=1 during the wait and 0 afterwards.
REQ-034 Contention: both requesters hold valid continuously with distinct data -> grants alternate 0,1,0,1 starting with 0, with one write per cycle.
REQ-035 Backpressure: req1 pushes 2 writes while req0 monopolises the port for 2 cycles -> req1_ready=0 while count=2, no loss, and FIFO order is kept.
REQ-036 r_0 filter: req0 writes reg=0 and then reg=5 -> the grant slot for reg 0 has reg_write=0, pending never shows bit 0, and reg 5 is written next.
REQ-037 Same register: req0 and req1 both target reg 7 in the same cycle after reset -> req0's data is written first, then req1's, and pending[7] clears after the second write.
REQ-038 Mid-flight reset: queue 3 writes, then pulse rst_n low for half a cycle -> outputs go to 0 asynchronously, and no write appears after release.
